// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: operand/opcode input channel plus result output channel.
interface logic_gate_pipe_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned N_IN  = 2,
    parameter int unsigned CNT_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_op;
    logic [W*N_IN-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic                out_err;
    logic [CNT_W-1:0]    out_count;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_count
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err, out_count
    );
endinterface

// File: rtl/logic_gate_pipe.sv
// Two-stage pipelined multi-operand bitwise gate with valid/ready on both sides and a
// completed-transfer counter.
module logic_gate_pipe #(
    parameter int unsigned W     = 8,
    parameter int unsigned N_IN  = 2,
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    logic_gate_pipe_if.slave  bus
);
    localparam logic [2:0] OpAnd  = 3'b000;
    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpXor  = 3'b010;
    localparam logic [2:0] OpNand = 3'b011;
    localparam logic [2:0] OpNor  = 3'b100;
    localparam logic [2:0] OpXnor = 3'b101;
    localparam logic [2:0] OpPass = 3'b110;

    logic                s1_valid_q, s1_valid_d;
    logic [W*N_IN-1:0]   s1_data_q;
    logic [2:0]          s1_op_q;
    logic                s2_valid_q, s2_valid_d;
    logic [W-1:0]        s2_data_q;
    logic                s2_err_q;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                s2_adv, s1_adv, in_fire, out_fire;
    logic [W-1:0]        fold_and, fold_or, fold_xor, res_data;
    logic                res_err;

    // Ready chain is purely combinational so a full pipe still streams one item per cycle.
    assign s2_adv   = !s2_valid_q || bus.out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = s2_valid_q && bus.out_ready;

    assign bus.in_ready  = !s1_valid_q || s2_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_err   = s2_err_q;
    assign bus.out_count = count_q;

    always_comb begin
        fold_and = '1;
        fold_or  = '0;
        fold_xor = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            fold_and = fold_and & s1_data_q[k*W +: W];
            fold_or  = fold_or  | s1_data_q[k*W +: W];
            fold_xor = fold_xor ^ s1_data_q[k*W +: W];
        end
        res_err = 1'b0;
        case (s1_op_q)
            OpAnd:   res_data = fold_and;
            OpOr:    res_data = fold_or;
            OpXor:   res_data = fold_xor;
            OpNand:  res_data = ~fold_and;
            OpNor:   res_data = ~fold_or;
            OpXnor:  res_data = ~fold_xor;
            OpPass:  res_data = s1_data_q[W-1:0];
            default: begin
                res_data = '0;
                res_err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        count_d    = count_q;
        if (in_fire)       s1_valid_d = 1'b1;
        else if (s1_adv)   s1_valid_d = 1'b0;
        if (s1_adv)        s2_valid_d = 1'b1;
        else if (out_fire) s2_valid_d = 1'b0;
        if (out_fire)      count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            count_q    <= count_d;
            // Payload registers move only on a transfer, so idle X on in_data never propagates.
            if (in_fire) begin
                s1_data_q <= bus.in_data;
                s1_op_q   <= bus.in_op;
            end
            if (s1_adv) begin
                s2_data_q <= res_data;
                s2_err_q  <= res_err;
            end
        end
    end
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomised and directed bench for logic_gate_pipe against an in-order queue model.
module tb_logic_gate_pipe;
    localparam int unsigned W     = 8;
    localparam int unsigned N_IN  = 3;
    localparam int unsigned CNT_W = 3;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           acc;
    } item_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    item_t            q[$];
    logic [CNT_W-1:0] mcount = '0;

    logic_gate_pipe_if #(.W(W), .N_IN(N_IN), .CNT_W(CNT_W)) bus ();

    logic_gate_pipe #(.W(W), .N_IN(N_IN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-bit count of ones across operands decides every reduction.
    function automatic logic [W:0] ref_gate(input logic [2:0] op, input logic [W*N_IN-1:0] d);
        logic [W-1:0] r;
        int ones;
        r = '0;
        if (op == 3'd7) return {1'b1, {W{1'b0}}};
        for (int b = 0; b < int'(W); b++) begin
            ones = 0;
            for (int k = 0; k < int'(N_IN); k++) ones += int'(d[k*W + b]);
            case (op)
                3'd0:    r[b] = (ones == int'(N_IN));
                3'd1:    r[b] = (ones != 0);
                3'd2:    r[b] = (ones % 2 == 1);
                3'd3:    r[b] = (ones != int'(N_IN));
                3'd4:    r[b] = (ones == 0);
                3'd5:    r[b] = (ones % 2 == 0);
                default: r[b] = d[b];
            endcase
        end
        return {1'b0, r};
    endfunction

    // Drive one cycle's inputs at the negedge, check outputs, advance the model, wait a cycle.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [W*N_IN-1:0] d,
                         input logic ordy, output logic accepted);
        logic front_ok;
        logic [W:0] r;
        item_t it;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", bus.in_ready, (q.size() < 2) || ordy);
        front_ok = (q.size() > 0) && (edges >= q[0].acc + 1);
        chk("out_valid", bus.out_valid, front_ok);
        if (front_ok && bus.out_valid) begin
            chk("out_data", bus.out_data, q[0].data);
            chk("out_err", bus.out_err, q[0].err);
        end
        chk("out_count", bus.out_count, mcount);
        accepted = v && bus.in_ready;
        if (bus.out_valid && ordy && q.size() > 0) begin
            void'(q.pop_front());
            mcount = mcount + 1'b1;
        end
        if (accepted) begin
            r = ref_gate(op, d);
            it.data = r[W-1:0];
            it.err  = r[W];
            it.acc  = edges + 1;
            q.push_back(it);
        end
        @(negedge clk);
        edges++;
    endtask

    initial begin : main
        logic acc;
        logic [W-1:0] lit [8];
        logic [W:0] r;
        int sent;
        lit = '{8'h80, 8'hFE, 8'h96, 8'h7F, 8'h01, 8'h69, 8'hF0, 8'h00};

        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = 3'd1;
        bus.in_data = 24'h123456;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_err", bus.out_err, 1'b0);
        chk("rst_out_count", bus.out_count, 0);
        @(negedge clk);
        chk("rst_hold_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;

        // AND truth table over all-ones/all-zeros operands, third operand all ones.
        cycle(1, 3'd0, {8'hFF, 8'h00, 8'h00}, 1, acc);
        cycle(1, 3'd0, {8'hFF, 8'h00, 8'hFF}, 1, acc);
        cycle(1, 3'd0, {8'hFF, 8'hFF, 8'hFF}, 1, acc);
        cycle(1, 3'd0, {8'hFF, 8'hFF, 8'h00}, 1, acc);

        // Every opcode on F0/CC/AA, pinning the model to hand-computed results.
        for (int i = 0; i < 8; i++) begin
            r = ref_gate(3'(i), {8'hAA, 8'hCC, 8'hF0});
            chk("pin_model_data", r[W-1:0], lit[i]);
            chk("pin_model_err", r[W], (i == 7));
            cycle(1, 3'(i), {8'hAA, 8'hCC, 8'hF0}, 1, acc);
        end
        for (int i = 0; i < 3; i++) cycle(0, 3'd0, '0, 1, acc);

        // Backpressure: five transactions with the consumer stalled for four cycles.
        sent = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(sent < 5, 3'($urandom_range(0, 7)), 24'($urandom()), !(i >= 1 && i <= 4), acc);
            if (acc) sent++;
        end
        chk("bp_all_sent", sent, 5);

        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 24'($urandom()),
                  $urandom_range(0, 2) != 0, acc);
        for (int i = 0; i < 4; i++) cycle(0, 3'd0, '0, 1, acc);
        chk("drained", q.size(), 0);

        // Reset with both stages occupied.
        for (int i = 0; i < 3; i++) cycle(1, 3'd2, 24'($urandom()), 0, acc);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_count", bus.out_count, 0);
        chk("mid_rst_data", bus.out_data, 0);
        q.delete();
        mcount = '0;
        @(negedge clk);
        edges++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 3'd0, '0, 1, acc);

        // Nine transfers on a 3-bit counter wrap through zero to one.
        for (int i = 0; i < 9; i++) cycle(1, 3'd1, 24'($urandom()), 1, acc);
        cycle(0, 3'd0, '0, 1, acc);
        cycle(0, 3'd0, '0, 1, acc);
        #1;
        chk("wrap_count", bus.out_count, 3'd1);
        chk("wrap_idle", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
